// File: rtl/cf_uart_rx_fifo.sv
// cf_uart_rx_fifo: UART receive engine with an integrated receive FIFO.
//
// Receives asynchronous serial frames on rx with 16x oversampling. Each received frame is pushed
// into a circular FIFO together with its parity and framing error flags.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en                  receiver enable (the FIFO stays usable while low)
//   prescale            oversample tick every prescale+1 cycles, 16 ticks per bit
//   data_size           data bits per frame, 5..MDW (other values use MDW)
//   parity_type         0 none, 1 odd, 2 even, 3 stick-0, 4 stick-1, 5..7 none
//   stop_bits_count     0 one stop bit, 1 two stop bits
//   timeout_bits        idle timeout in bit times, 0 disables
//   rx                  serial input, idle high, asynchronous
//   rd                  pop FIFO head
//   rdata, rerr         FIFO head data and flags ([0] parity, [1] framing)
//   empty, full, level  FIFO status
//   overrun             pulse: frame dropped because the FIFO was full
//   break_det           pulse: break frame seen
//   timeout             pulse: idle timeout with data pending
module cf_uart_rx_fifo #(
    parameter int unsigned MDW = 9,
    parameter int unsigned FAW = 4,
    parameter int unsigned PW  = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en,
    input  logic [PW-1:0]  prescale,
    input  logic [3:0]     data_size,
    input  logic [2:0]     parity_type,
    input  logic           stop_bits_count,
    input  logic [5:0]     timeout_bits,
    input  logic           rx,
    input  logic           rd,
    output logic [MDW-1:0] rdata,
    output logic [1:0]     rerr,
    output logic           empty,
    output logic           full,
    output logic [FAW:0]   level,
    output logic           overrun,
    output logic           break_det,
    output logic           timeout
);

    localparam int unsigned Depth = 1 << FAW;
    localparam int unsigned EW    = MDW + 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser and prescaler
    // ------------------------------------------------------------------
    logic          rx_meta_q, rx_sync_q;
    logic [PW-1:0] presc_q;
    logic          tick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick = en && (presc_q == prescale);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Configuration decode
    // ------------------------------------------------------------------
    logic [3:0] eff_size;
    logic [3:0] last_bit;
    logic       par_en;

    always_comb begin
        if (data_size >= 4'd5 && 32'(data_size) <= MDW) begin
            eff_size = data_size;
        end else begin
            eff_size = 4'(MDW);
        end
    end

    assign last_bit = eff_size - 4'd1;
    assign par_en   = (parity_type >= 3'd1) && (parity_type <= 3'd4);

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e         state_q;
    logic [3:0]     tcnt_q;
    logic [3:0]     bit_q;
    logic [MDW-1:0] data_q;
    logic [MDW-1:0] data_d;
    logic           par_bit_q;
    logic           perr_q;
    logic           ferr_q;
    logic           brk_wait_q;

    logic           mid;
    logic           bit_end;
    logic           perr_calc;
    logic           push;
    logic           brk;
    logic [EW-1:0]  push_word;

    // Sample in the middle of the bit, advance state at the end of it.
    assign mid     = tick && (tcnt_q == 4'd7);
    assign bit_end = tick && (tcnt_q == 4'd15);

    always_comb begin
        data_d = data_q;
        for (int unsigned i = 0; i < MDW; i++) begin
            if (bit_q == 4'(i)) begin
                data_d[i] = rx_sync_q;
            end
        end
    end

    always_comb begin
        case (parity_type)
            3'd1:    perr_calc = ~(^data_q ^ rx_sync_q);
            3'd2:    perr_calc = ^data_q ^ rx_sync_q;
            3'd3:    perr_calc = rx_sync_q;
            3'd4:    perr_calc = ~rx_sync_q;
            default: perr_calc = 1'b0;
        endcase
    end

    // Frame completion happens on the sample cycle of the last stop bit, so the
    // push is decoded combinationally and lands in the FIFO on that same edge.
    always_comb begin
        push = 1'b0;
        brk  = 1'b0;
        if (mid) begin
            if (state_q == StStop1) begin
                if (!rx_sync_q && (data_q == '0) && (!par_en || !par_bit_q)) begin
                    brk = 1'b1;
                end else if (!stop_bits_count) begin
                    push = 1'b1;
                end
            end else if (state_q == StStop2) begin
                push = 1'b1;
            end
        end
    end

    assign push_word = {ferr_q | ~rx_sync_q, perr_q, data_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            tcnt_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_wait_q <= 1'b0;
        end else if (!en) begin
            state_q    <= StIdle;
            tcnt_q     <= '0;
            bit_q      <= '0;
            brk_wait_q <= 1'b0;
        end else begin
            if (state_q != StIdle && tick) begin
                tcnt_q <= tcnt_q + 4'd1;
            end
            case (state_q)
                StIdle: begin
                    if (brk_wait_q) begin
                        // After a break the line must be seen high before a new start.
                        if (tick && rx_sync_q) begin
                            brk_wait_q <= 1'b0;
                        end
                    end else if (!rx_sync_q) begin
                        state_q   <= StStart;
                        tcnt_q    <= '0;
                        bit_q     <= '0;
                        data_q    <= '0;
                        par_bit_q <= 1'b0;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (mid && rx_sync_q) begin
                        state_q <= StIdle;
                    end else if (bit_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (mid) begin
                        data_q <= data_d;
                    end
                    if (bit_end) begin
                        if (bit_q == last_bit) begin
                            bit_q   <= '0;
                            state_q <= par_en ? StParity : StStop1;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (mid) begin
                        par_bit_q <= rx_sync_q;
                        perr_q    <= perr_calc;
                    end
                    if (bit_end) begin
                        state_q <= StStop1;
                    end
                end
                StStop1: begin
                    if (brk) begin
                        state_q    <= StIdle;
                        brk_wait_q <= 1'b1;
                    end else if (push) begin
                        state_q <= StIdle;
                    end else begin
                        if (mid) begin
                            ferr_q <= ~rx_sync_q;
                        end
                        if (bit_end) begin
                            state_q <= StStop2;
                        end
                    end
                end
                StStop2: begin
                    if (push) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [Depth];
    logic [FAW:0]  wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] head;
    logic          wr_en, rd_en;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                   (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);

    // Full is judged before a same-cycle pop, so push+rd while full drops the push.
    assign wr_en = push && !full;
    assign rd_en = rd && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q[FAW-1:0]] <= push_word;
        end
    end

    assign head  = mem[rd_ptr_q[FAW-1:0]];
    assign rdata = empty ? '0 : head[MDW-1:0];
    assign rerr  = empty ? 2'b00 : head[EW-1:MDW];

    // ------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------
    logic [9:0] to_cnt_q;
    logic [9:0] to_thresh;
    logic       to_armed_q;
    logic       to_step;
    logic       to_fire;

    assign to_thresh = {timeout_bits, 4'b0000};
    assign to_step   = tick && (state_q == StIdle);
    assign to_fire   = to_armed_q && (timeout_bits != 6'd0) && !empty && to_step &&
                       ((to_cnt_q + 10'd1) == to_thresh);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q   <= '0;
            to_armed_q <= 1'b1;
        end else if (push || rd) begin
            to_cnt_q   <= '0;
            to_armed_q <= 1'b1;
        end else if (to_fire) begin
            to_cnt_q   <= '0;
            to_armed_q <= 1'b0;
        end else if (to_step && (to_cnt_q != '1)) begin
            to_cnt_q <= to_cnt_q + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registered event pulses
    // ------------------------------------------------------------------
    logic overrun_q, break_q, timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            overrun_q <= push && full;
            break_q   <= brk;
            timeout_q <= to_fire;
        end
    end

    assign overrun   = overrun_q;
    assign break_det = break_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cf_uart_rx_fifo.sv
// Directed testbench for cf_uart_rx_fifo. Runs with prescale = 0, so one bit is 16 clocks.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cf_uart_rx_fifo;

    localparam int MDW = 9;
    localparam int FAW = 4;
    localparam int PW  = 16;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           en;
    logic [PW-1:0]  prescale;
    logic [3:0]     data_size;
    logic [2:0]     parity_type;
    logic           stop_bits_count;
    logic [5:0]     timeout_bits;
    logic           rx;
    logic           rd;
    logic [MDW-1:0] rdata;
    logic [1:0]     rerr;
    logic           empty;
    logic           full;
    logic [FAW:0]   level;
    logic           overrun;
    logic           break_det;
    logic           timeout;

    cf_uart_rx_fifo #(
        .MDW(MDW),
        .FAW(FAW),
        .PW (PW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en             (en),
        .prescale       (prescale),
        .data_size      (data_size),
        .parity_type    (parity_type),
        .stop_bits_count(stop_bits_count),
        .timeout_bits   (timeout_bits),
        .rx             (rx),
        .rd             (rd),
        .rdata          (rdata),
        .rerr           (rerr),
        .empty          (empty),
        .full           (full),
        .level          (level),
        .overrun        (overrun),
        .break_det      (break_det),
        .timeout        (timeout)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor: pulse counters and distance from the last push to a timeout pulse.
    int           brk_cnt;
    int           ovr_cnt;
    int           to_cnt;
    int           since_push;
    int           to_at;
    logic [FAW:0] lvl_prev;

    always @(negedge clk_i) begin
        if (rst_i) begin
            brk_cnt    <= 0;
            ovr_cnt    <= 0;
            to_cnt     <= 0;
            since_push <= 0;
            to_at      <= -1;
            lvl_prev   <= '0;
        end else begin
            lvl_prev <= level;
            if (level > lvl_prev) since_push <= 0;
            else since_push <= since_push + 1;
            if (break_det) brk_cnt <= brk_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (timeout) begin
                to_cnt <= to_cnt + 1;
                to_at  <= since_push + 1;
            end
        end
    end

    // Frame driver. cyc counts falling edges since frame start; push_at records the
    // first edge at which level moved; rd is raised for the clock edge numbered rd_at.
    int           cyc;
    int           push_at;
    int           rd_at = -1;
    logic [FAW:0] lvl0;

    task automatic drive_bit(input logic b);
        rx = b;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            cyc++;
            rd = (cyc + 1 == rd_at);
            if (push_at < 0 && level != lvl0) push_at = cyc;
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input bit has_par,
                              input logic pbit, input logic s1, input bit two, input logic s2);
        logic [8:0] dv;
        dv      = d;
        cyc     = 0;
        push_at = -1;
        lvl0    = level;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(dv[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(s1);
        if (two) drive_bit(s2);
        drive_bit(1'b1);
        rd = 1'b0;
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_frame({1'b0, d}, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic pop;
        @(negedge clk_i);
        rd = 1'b1;
        @(negedge clk_i);
        rd = 1'b0;
    endtask

    int cal;

    initial begin
        en              = 1'b1;
        prescale        = '0;
        data_size       = 4'd8;
        parity_type     = 3'd0;
        stop_bits_count = 1'b0;
        timeout_bits    = 6'd0;
        rx              = 1'b1;
        rd              = 1'b0;

        // Reset values
        repeat (3) @(negedge clk_i);
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        check_eq("rst_rerr", 32'(rerr), 32'h0);
        check_eq("rst_empty", 32'(empty), 32'h1);
        check_eq("rst_full", 32'(full), 32'h0);
        check_eq("rst_level", 32'(level), 32'h0);
        check_eq("rst_pulses", {29'b0, overrun, break_det, timeout}, 32'h0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // 8N1 0xA5
        send_8n1(8'hA5);
        check_eq("8n1_level", 32'(level), 32'h1);
        check_eq("8n1_rdata", 32'(rdata), 32'hA5);
        check_eq("8n1_rerr", 32'(rerr), 32'h0);
        pop();
        check_eq("8n1_rd_empty", 32'(empty), 32'h1);
        check_eq("8n1_rd_level", 32'(level), 32'h0);

        // 8E1 0x03 with wrong parity bit 1
        parity_type = 3'd2;
        send_frame(9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("8e1_rdata", 32'(rdata), 32'h03);
        check_eq("8e1_rerr", 32'(rerr), 32'h1);
        pop();

        // 9O2 0x1FF, correct parity 0, second stop bit low
        data_size       = 4'd9;
        parity_type     = 3'd1;
        stop_bits_count = 1'b1;
        send_frame(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("9o2_rdata", 32'(rdata), 32'h1FF);
        check_eq("9o2_rerr", 32'(rerr), 32'h2);
        pop();

        // 5-bit stick-1 with parity bit 0: parity error, data zero-extended
        data_size       = 4'd5;
        parity_type     = 3'd4;
        stop_bits_count = 1'b0;
        send_frame(9'h013, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("5s1_rdata", 32'(rdata), 32'h13);
        check_eq("5s1_rerr", 32'(rerr), 32'h1);
        pop();

        // False start: rx low for 4 cycles only
        data_size   = 4'd8;
        parity_type = 3'd0;
        rx = 1'b0;
        repeat (4) @(negedge clk_i);
        rx = 1'b1;
        repeat (60) @(negedge clk_i);
        check_eq("false_start_level", 32'(level), 32'h0);
        check_eq("false_start_brk", 32'(brk_cnt), 32'h0);

        // Break frame
        send_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk_i);
        check_eq("break_pulses", 32'(brk_cnt), 32'h1);
        check_eq("break_level", 32'(level), 32'h0);

        // Disable mid-DATA, then receive 0x5A
        cyc = 0; push_at = -1; lvl0 = level;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (8) @(negedge clk_i);
        en = 1'b0;
        repeat (200) @(negedge clk_i);
        en = 1'b1;
        repeat (20) @(negedge clk_i);
        check_eq("dis_level", 32'(level), 32'h0);
        send_8n1(8'h5A);
        check_eq("reen_level", 32'(level), 32'h1);
        check_eq("reen_rdata", 32'(rdata), 32'h5A);
        check_eq("reen_rerr", 32'(rerr), 32'h0);
        pop();

        // Timeout: 4 bit times = 64 ticks after push, single pulse, re-armed by rd + frame
        timeout_bits = 6'd4;
        send_8n1(8'h3C);
        repeat (200) @(negedge clk_i);
        check_eq("to_count1", 32'(to_cnt), 32'h1);
        check_eq("to_delay1", 32'(to_at), 32'd64);
        pop();
        repeat (150) @(negedge clk_i);
        check_eq("to_empty_nopulse", 32'(to_cnt), 32'h1);
        send_8n1(8'hC3);
        repeat (200) @(negedge clk_i);
        check_eq("to_count2", 32'(to_cnt), 32'h2);
        check_eq("to_delay2", 32'(to_at), 32'd64);
        pop();
        timeout_bits = 6'd0;

        // Fill: 17 frames, single overrun on the 17th
        for (int i = 0; i < 17; i++) begin
            send_8n1(8'(8'h10 + i));
            if (i == 0) cal = push_at;
        end
        check_eq("full_flag", 32'(full), 32'h1);
        check_eq("full_level", 32'(level), 32'd16);
        check_eq("full_overrun", 32'(ovr_cnt), 32'h1);
        check_eq("full_head", 32'(rdata), 32'h10);

        // Push with simultaneous rd while full: push dropped, pop performed
        rd_at = cal;
        send_8n1(8'h77);
        rd_at = -1;
        check_eq("full_rdpush_level", 32'(level), 32'd15);
        check_eq("full_rdpush_overrun", 32'(ovr_cnt), 32'h2);
        check_eq("full_rdpush_head", 32'(rdata), 32'h11);
        for (int i = 0; i < 15; i++) pop();
        check_eq("drain_empty", 32'(empty), 32'h1);
        pop();
        check_eq("rd_empty_level", 32'(level), 32'h0);

        // Reset mid-frame with three entries held
        for (int i = 0; i < 3; i++) send_8n1(8'(8'h21 + i));
        check_eq("pre_rst_level", 32'(level), 32'h3);
        rx = 1'b0;
        repeat (40) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("midrst_level", 32'(level), 32'h0);
        check_eq("midrst_empty", 32'(empty), 32'h1);
        check_eq("midrst_rdata", 32'(rdata), 32'h0);
        rx    = 1'b1;
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check_eq("post_rst_level", 32'(level), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
